// File: rtl/dividend_rebuild_if.sv
// Operand/result bundle for the dividend rebuilder: Start plus A/Q/R in, B and status out.
// The master drives the request; the slave (the rebuilder) returns the result.
interface dividend_rebuild_if #(
  parameter int N = 8
);
  logic           Start;
  logic [N-1:0]   A;
  logic [N-1:0]   Q;
  logic [N-1:0]   R;
  logic [2*N-1:0] B;
  logic           Busy;
  logic           Done;
  logic           Invalid;

  modport master (
    output Start, A, Q, R,
    input  B, Busy, Done, Invalid
  );

  modport slave (
    input  Start, A, Q, R,
    output B, Busy, Done, Invalid
  );
endinterface

// File: rtl/dividend_rebuild.sv
// Shift-add multiply-accumulate rebuilding a dividend B = Q*A + R over a fixed N cycles,
// the inverse of the restoring divider, with the same Start/Busy/Done handshake.
module dividend_rebuild #(
  parameter int N = 8
) (
  input  logic                CLK,
  input  logic                Reset_n,
  dividend_rebuild_if.slave   io_bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]     r_state;
  logic [2*N-1:0] r_acc;
  logic [2*N-1:0] r_mcand;
  logic [N-1:0]   r_mplier;
  logic [CW-1:0]  r_count;
  logic           r_inv_pend;
  logic [2*N-1:0] r_b;
  logic           r_busy;
  logic           r_done;
  logic           r_invalid;

  logic [2*N-1:0] w_addend;
  logic [2*N-1:0] w_sum;
  logic           w_last;
  logic           w_check;

  // Partial-product selection, next accumulator value and operand check
  always_comb begin
    w_addend = {(2*N){1'b0}};
    if (r_mplier[0]) begin
      w_addend = r_mcand;
    end else begin
      w_addend = {(2*N){1'b0}};
    end
    // No carry out is possible: the largest result is 2^2N - 2^N.
    w_sum   = r_acc + w_addend;
    w_last  = (r_count == CW'(N - 1));
    w_check = (io_bus.A == {N{1'b0}}) | (io_bus.R >= io_bus.A);
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= S_IDLE;
      r_acc      <= {(2*N){1'b0}};
      r_mcand    <= {(2*N){1'b0}};
      r_mplier   <= {N{1'b0}};
      r_count    <= {CW{1'b0}};
      r_inv_pend <= 1'b0;
      r_b        <= {(2*N){1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_invalid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (io_bus.Start) begin
            r_acc      <= {{N{1'b0}}, io_bus.R};
            r_mcand    <= {{N{1'b0}}, io_bus.A};
            r_mplier   <= io_bus.Q;
            r_count    <= {CW{1'b0}};
            r_inv_pend <= w_check;
            r_done     <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_CALC;
          end else begin
            r_state    <= r_state;
          end
        end
        S_CALC: begin
          r_acc    <= w_sum;
          r_mcand  <= {r_mcand[2*N-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[N-1:1]};
          r_count  <= r_count + CW'(1);
          if (w_last) begin
            r_b       <= w_sum;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_invalid <= r_inv_pend;
            r_state   <= S_DONE;
          end else begin
            r_state   <= S_CALC;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.B       = r_b;
  assign io_bus.Busy    = r_busy;
  assign io_bus.Done    = r_done;
  assign io_bus.Invalid = r_invalid;

endmodule
